// File: rtl/seq_divider_4b_if.sv
// Purpose: start/ready/valid handshake and operand/result bus for seq_divider_4b.
// Latency: none, this is wiring only.
// Backpressure: the master may only have start accepted while the slave drives ready=1.
interface seq_divider_4b_if #(
  parameter int WIDTH = 4
) ();

  // Request side, driven by the sequencing control logic
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;

  // Response side, driven by the divider
  logic             ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             valid;
  logic             div_by_zero;

  // Control logic issuing divisions
  modport master (
    output start,
    output dividend,
    output divisor,
    input  ready,
    input  quotient,
    input  remainder,
    input  valid,
    input  div_by_zero
  );

  // Divider datapath
  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output ready,
    output quotient,
    output remainder,
    output valid,
    output div_by_zero
  );

endinterface

// File: rtl/seq_divider_4b.sv
// Purpose: multi-cycle restoring divider, one quotient bit per clock; DIV_SIGNED_EN selects two's complement operands.
// Latency: accepted start in cycle N gives valid in N+WIDTH+1 (N+1 for a zero divisor); next start accepted in N+WIDTH+2.
// Backpressure: ready is low from the cycle after acceptance until the valid cycle; start while ready=0 is dropped.
module seq_divider_4b #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider_4b_if.slave bus
);

  // Iteration counter must hold 0..WIDTH-1 with room to spare
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control state
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Working registers: partial remainder, quotient shift register, latched divisor
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;

  // Registered outputs
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

`ifdef DIV_SIGNED_EN
  // Result signs recorded at acceptance, applied when the magnitudes are done
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
`endif

  // Combinational datapath signals
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             step_ok;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    // The partial remainder is always below the divisor, so after the shift
    // it fits WIDTH+1 bits and the trial's MSB is a clean sign bit.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dsr_q};
    step_ok  = ~trial[WIDTH];
    rem_step = step_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], step_ok};
  end

  // Operand magnitudes at acceptance and sign fix-up of the final step
  always_comb begin
`ifdef DIV_SIGNED_EN
    // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned
    dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + ONE) : bus.dividend;
    dsr_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor  + ONE) : bus.divisor;
    // Negation wraps, so most-negative / -1 naturally returns most-negative
    q_out   = qneg_q ? (~quo_step + ONE) : quo_step;
    r_out   = rneg_q ? (~rem_step + ONE) : rem_step;
`else
    dvd_mag = bus.dividend;
    dsr_mag = bus.divisor;
    q_out   = quo_step;
    r_out   = rem_step;
`endif
  end

  // Next-state and next-output logic for the IDLE/CALC/DONE sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    ready_d     = ready_q;
    valid_d     = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
`endif

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.start) begin
          ready_d = 1'b0;
          dsr_d   = dsr_mag;
`ifdef DIV_SIGNED_EN
          qneg_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          rneg_d  = bus.dividend[WIDTH-1];
`endif
          if (bus.divisor == '0) begin
            // Zero divisor skips the iterations; results publish next cycle
            state_d     = DONE;
            valid_d     = 1'b1;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            rem_d   = '0;
            quo_d   = dvd_mag;
            cnt_d   = '0;
          end
        end
      end

      CALC: begin
        ready_d = 1'b0;
        rem_d   = rem_step;
        quo_d   = quo_step;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          // Outputs are registered, so they are loaded on the way into DONE
          state_d     = DONE;
          valid_d     = 1'b1;
          quotient_d  = q_out;
          remainder_d = r_out;
          dbz_d       = 1'b0;
        end
      end

      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
`endif
    end
  end

  assign bus.ready       = ready_q;
  assign bus.valid       = valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_4b.sv
// Purpose: scoreboard bench for seq_divider_4b (unsigned, or signed when DIV_SIGNED_EN is defined).
// Latency: expected completion cycle is carried with each scoreboard entry.
// Backpressure: start is only issued when the bench expects ready=1, except the deliberate hold test.
module tb_seq_divider_4b;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_divider_4b_if #(.WIDTH(W)) bus ();

  seq_divider_4b #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt  = 0;
  int   err_cnt  = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   exp_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference result and completion cycle for an operation accepted in cycle n
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    exp_t e;
    int   sa;
    int   sbv;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    e.cyc = n + ((b == '0) ? 1 : W + 1);
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      e.q = W'(sa / sbv);
      e.r = W'(sa % sbv);
`else
      e.q = a / b;
      e.r = a % b;
`endif
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Output monitor: every valid must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", bus.valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("quotient",    bus.quotient,    e.q);
        chk("remainder",   bus.remainder,   e.r);
        chk("div_by_zero", bus.div_by_zero, e.dz);
        chk("valid_cycle", cyc,             e.cyc);
        done_cnt++;
      end
    end
  end

  // Drive a start pulse in the next cycle, optionally recording the expectation
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    @(posedge clk);
    #1;
    chk("ready_at_start", bus.ready, 1'b1);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) begin
      sb.push_back(model(a, b, cyc));
      exp_done++;
    end
  endtask

  // Wait (bounded) for all recorded operations; ready must be low meanwhile
  task automatic wait_done(input bit chk_busy);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (chk_busy) chk("ready_busy", bus.ready, 1'b0);
      #1;
      if (done_cnt >= exp_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("completion", done_cnt, exp_done);
  endtask

  // One complete division; operands are scrambled after acceptance
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b, 1'b1);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    wait_done(1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready",     bus.ready,       1'b1);
    chk("rst_valid",     bus.valid,       1'b0);
    chk("rst_quotient",  bus.quotient,    4'h0);
    chk("rst_remainder", bus.remainder,   4'h0);
    chk("rst_dbz",       bus.div_by_zero, 1'b0);

    // Directed vectors; each next start lands the cycle after valid
    do_op(4'd13, 4'd3);
    do_op(4'd7,  4'd0);
    do_op(4'd15, 4'd1);
    do_op(4'd5,  4'd9);
    do_op(4'd9,  4'd4);

    // start held high with other operands during CALC of 12/5
    issue(4'd12, 4'd5, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk("ready_hold", bus.ready, (k == 6) ? 1'b1 : 1'b0);
      bus.start    = 1'b1;
      bus.dividend = 4'd14;
      bus.divisor  = 4'd2;
      if (k == 6) begin
        sb.push_back(model(4'd14, 4'd2, cyc));
        exp_done++;
      end
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(1'b0);

    // Reset in the third CALC cycle of 11/2 aborts it
    issue(4'd11, 4'd2, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready",     bus.ready,       1'b1);
    chk("abort_valid",     bus.valid,       1'b0);
    chk("abort_quotient",  bus.quotient,    4'h0);
    chk("abort_remainder", bus.remainder,   4'h0);
    chk("abort_dbz",       bus.div_by_zero, 1'b0);
    repeat (8) @(negedge clk);
    do_op(4'd11, 4'd2);

    // Sign-relevant patterns (plain unsigned values without DIV_SIGNED_EN)
    do_op(4'h9, 4'h2);
    do_op(4'h7, 4'hE);
    do_op(4'h8, 4'hF);
    do_op(4'h8, 4'h0);

    // Random sweep
    repeat (25) do_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/seq_divider_4b.md
Name: seq_divider_4b

Overview:
Multi-cycle unsigned restoring divider. It is the inverse arithmetic counterpart of the 4-bit adder/subtractor datapath and produces one quotient bit per clock using a conditional subtract-and-restore step. It sits beside the adder/subtractor in the arithmetic unit and uses a start/ready/valid handshake so the control logic can sequence division operations.

Parameters:
WIDTH, 4, operand/quotient/remainder width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a division; accepted only when ready=1
dividend  input  WIDTH  numerator, sampled on the accepted start cycle
divisor  input  WIDTH  denominator, sampled on the accepted start cycle
ready  output  1  high while idle and able to accept start
quotient  output  WIDTH  result quotient; held until the next completion
remainder  output  WIDTH  result remainder; held until the next completion
valid  output  1  one-cycle pulse when quotient/remainder/div_by_zero are updated
div_by_zero  output  1  high with valid when divisor was 0; held with the results

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state is updated only on the rising edge of clk.
- Reset values: state=IDLE, ready=1, valid=0, quotient=0, remainder=0, div_by_zero=0, iteration count=0.
- States:
  - IDLE: ready=1. When start=1, latch the operands. If divisor==0, go to DONE. Otherwise clear the partial remainder, load the quotient shift register with dividend, clear the count and go to CALC.
  - CALC: ready=0. Each cycle: shift {partial remainder, quotient reg} left by 1; trial = partial remainder - divisor, computed at WIDTH+1 bits. If trial is non-negative, partial remainder = trial and the new quotient LSB = 1; otherwise keep the remainder and the LSB = 0. Count increments. After WIDTH iterations, go to DONE.
  - DONE: ready=0. Drive quotient/remainder/div_by_zero from the internal registers and assert valid=1 for exactly this cycle. Go to IDLE next cycle.
- Latency: start accepted in cycle N gives valid=1 in cycle N+WIDTH+1 (cycle N+5 for WIDTH=4). Divide-by-zero gives valid in cycle N+1. The block can accept a new start in cycle N+WIDTH+2.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
- div_by_zero is cleared to 0 on any normal completion.
- start while ready=0 is ignored. It is not queued, and the operands are not re-sampled.
- Operand inputs may change freely after the accepted start cycle.
- rst asserted in any state (including mid-CALC) aborts the operation: no valid pulse, outputs return to reset values, and the next cycle is IDLE.
- Edge cases: dividend < divisor gives quotient=0 and remainder=dividend. Divisor=1 gives quotient=dividend and remainder=0. The result always satisfies dividend == quotient*divisor + remainder with remainder < divisor.

Optional Feature:
Macro: DIV_SIGNED_EN
- Defined: dividend/divisor/quotient/remainder are two's complement.
  - IDLE takes the absolute values of the operands and records the result signs.
  - DONE negates the magnitudes as required. The quotient truncates toward zero and the remainder takes the sign of the dividend.
  - The most-negative / -1 case returns quotient = most-negative (wrap) and remainder=0, with no flag.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Latency is unchanged.
- Not defined: unsigned only, with no sign logic synthesized.

Test Plan:
- Reset, then dividend=13, divisor=3, start pulse in cycle N -> ready=0 in N+1..N+5; valid=1 only in N+5 with quotient=4, remainder=1, div_by_zero=0; ready=1 in N+6.
- dividend=7, divisor=0 -> valid in N+1, quotient=15, remainder=7, div_by_zero=1. Then 15/1 -> quotient=15, remainder=0, div_by_zero=0.
- 5/9 -> quotient=0, remainder=5. Back-to-back: the second start issued the cycle after valid (9/4) -> quotient=2, remainder=1.
- start held high with new operands (14/2) throughout CALC of 12/5 -> the result stays quotient=2, remainder=2; then exactly one new operation begins when ready returns.
- rst asserted in the third CALC cycle of 11/2 -> no valid pulse, quotient=0, remainder=0, ready=1 the next cycle; a subsequent 11/2 gives quotient=5, remainder=1.
- With DIV_SIGNED_EN: -7/2 -> quotient=0xD (-3), remainder=0xF (-1); 7/-2 -> quotient=0xD, remainder=1; -8/-1 -> quotient=0x8, remainder=0.
